// File: rtl/apb_pkg.sv
// Shared definitions for the APB completer slice.
//   - completer state encoding (IDLE / WAIT / DONE)
//   - default bus widths
//   - index-width helper used to size the register-bank index
package apb_pkg;

    localparam int APB_DATA_W = 32;
    localparam int APB_ADDR_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_DONE = 2'b10
    } apb_state_t;

    // Number of index bits for a bank of 'depth' words (never below 1).
    function automatic int idx_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/apb_slave_regfile_if.sv
// APB bus bundle between the team's APB master and a completer.
//   psel, penable, pwrite, paddr, pwdata : master -> completer
//   pready, prdata, pslverr              : completer -> master
interface apb_slave_regfile_if
    import apb_pkg::*;
#(
    parameter int ADDR = APB_ADDR_W,
    parameter int DATA = APB_DATA_W
) ();

    logic            psel;
    logic            penable;
    logic            pwrite;
    logic [ADDR-1:0] paddr;
    logic [DATA-1:0] pwdata;
    logic            pready;
    logic [DATA-1:0] prdata;
    logic            pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output pready, prdata, pslverr
    );

endinterface

// File: rtl/apb_wait_counter.sv
// Loadable down-counter used to time the completer's wait states.
//   pclk     : clock, rising edge
//   presetn  : asynchronous active-low reset (counter -> 0)
//   load     : load load_val (has priority over dec)
//   load_val : value to load
//   dec      : decrement by one; saturates at zero
//   is_one   : counter equals 1
//   is_zero  : counter equals 0
module apb_wait_counter #(
    parameter int CW = 4
) (
    input  logic          pclk,
    input  logic          presetn,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic          is_one,
    output logic          is_zero
);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (dec && !is_zero) begin
            cnt_reg <= cnt_reg - CW'(1);
        end
    end

    assign is_one  = (cnt_reg == CW'(1));
    assign is_zero = (cnt_reg == '0);

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer with a word-addressed register bank and a fixed number of
// wait states before pready.
//   pclk    : clock, all logic on the rising edge
//   presetn : asynchronous active-low reset; clears state, outputs and bank
//   s       : APB bus (slave modport): psel/penable/pwrite/paddr/pwdata in,
//             pready/prdata/pslverr out (all outputs registered)
// Address/data are sampled when the transfer completes, not at setup: the
// read word is captured on the edge entering DONE, a write is committed on
// the edge leaving DONE.
module apb_slave_regfile
    import apb_pkg::*;
#(
    parameter int DATA        = APB_DATA_W,
    parameter int ADDR        = APB_ADDR_W,
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                pclk,
    input  logic                presetn,
    apb_slave_regfile_if.slave  s
);

    localparam int              IW      = idx_width(DEPTH);
    localparam logic [ADDR-1:0] SPAN    = ADDR'(4 * DEPTH);
    localparam logic [3:0]      WAIT_LD = 4'(WAIT_CYCLES);
    localparam bit              NO_WAIT = (WAIT_CYCLES == 0);

    apb_state_t      state_reg;
    apb_state_t      state_next;

    logic [DATA-1:0] regs_reg [DEPTH];
    logic            pready_reg;
    logic            pslverr_reg;
    logic [DATA-1:0] prdata_reg;

    logic            cnt_load;
    logic            cnt_dec;
    logic            cnt_is_one;
    logic            cnt_is_zero;

    logic            wr_en;
    logic            enter_done;
    logic            legal;
    logic [IW-1:0]   idx;

    // Decode: word index plus legality (aligned and inside the bank).
    assign idx   = s.paddr[IW+1:2];
    assign legal = (s.paddr[1:0] == 2'b00) && (s.paddr < SPAN);

    apb_wait_counter #(
        .CW(4)
    ) u_wait_counter (
        .pclk    (pclk),
        .presetn (presetn),
        .load    (cnt_load),
        .load_val(WAIT_LD),
        .dec     (cnt_dec),
        .is_one  (cnt_is_one),
        .is_zero (cnt_is_zero)
    );

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        wr_en      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                // Setup phase, or an access phase whose setup was never seen:
                // both start a transfer.
                if (s.psel) begin
                    if (NO_WAIT) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_WAIT;
                        cnt_load   = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (!s.psel) begin
                    // Abort: master withdrew, nothing is committed.
                    state_next = ST_IDLE;
                end else if (!s.penable) begin
                    // A fresh setup phase restarts the wait period.
                    cnt_load = 1'b1;
                end else if (cnt_is_one || cnt_is_zero) begin
                    state_next = ST_DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_DONE: begin
                // The completing cycle closes here whether or not the master
                // has already released psel, so the write does not depend
                // on psel.
                wr_en = s.pwrite && legal;
                if (s.psel && s.penable) begin
                    // Back-to-back transfer without a setup phase.
                    if (NO_WAIT) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_WAIT;
                        cnt_load   = 1'b1;
                    end
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign enter_done = (state_next == ST_DONE);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (wr_en) begin
            regs_reg[idx] <= s.pwdata;
        end
    end

    // Response registers: only non-zero in the cycle(s) spent in DONE.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            pready_reg  <= 1'b0;
            prdata_reg  <= '0;
            pslverr_reg <= 1'b0;
        end else begin
            pready_reg  <= enter_done;
            pslverr_reg <= enter_done && !legal;
            prdata_reg  <= (enter_done && legal && !s.pwrite) ? regs_reg[idx] : '0;
        end
    end

    assign s.pready  = pready_reg;
    assign s.prdata  = prdata_reg;
    assign s.pslverr = pslverr_reg;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: two instances, WAIT_CYCLES=0 (index 0) and
// WAIT_CYCLES=2 (index 1), sharing stimulus but selected separately.
// Expected responses come from a transfer-level model: a transfer completes
// in access cycle W+1, a read returns the bank word for the address held in
// the cycle before pready, a legal write lands when the pready cycle closes,
// and an illegal address gives pslverr=1 / prdata=0.
module tb_apb_slave_regfile;

    localparam int DEPTH = 16;

    logic        pclk;
    logic        presetn;
    logic [1:0]  psel_v;
    logic        penable_v;
    logic        pwrite_v;
    logic [31:0] paddr_v;
    logic [31:0] pwdata_v;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    bit          exp_pready  [2];
    logic [31:0] exp_prdata  [2];
    bit          exp_pslverr [2];
    logic [31:0] mem_m [2][DEPTH];

    int          first_k   [2];
    int          ready_cyc [2];
    logic [31:0] last_rd   [2];
    logic        last_err  [2];

    apb_slave_regfile_if #(.ADDR(32), .DATA(32)) bus0 ();
    apb_slave_regfile_if #(.ADDR(32), .DATA(32)) bus1 ();

    assign bus0.psel    = psel_v[0];
    assign bus0.penable = penable_v;
    assign bus0.pwrite  = pwrite_v;
    assign bus0.paddr   = paddr_v;
    assign bus0.pwdata  = pwdata_v;
    assign bus1.psel    = psel_v[1];
    assign bus1.penable = penable_v;
    assign bus1.pwrite  = pwrite_v;
    assign bus1.paddr   = paddr_v;
    assign bus1.pwdata  = pwdata_v;

    apb_slave_regfile #(.DATA(32), .ADDR(32), .DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .pclk   (pclk),
        .presetn(presetn),
        .s      (bus0)
    );

    apb_slave_regfile #(.DATA(32), .ADDR(32), .DEPTH(DEPTH), .WAIT_CYCLES(2)) dut1 (
        .pclk   (pclk),
        .presetn(presetn),
        .s      (bus1)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    always @(posedge pclk) cyc <= cyc + 1;

    function automatic logic rd_pready(input int d);
        return (d == 1) ? bus1.pready : bus0.pready;
    endfunction

    function automatic logic [31:0] rd_prdata(input int d);
        return (d == 1) ? bus1.prdata : bus0.prdata;
    endfunction

    function automatic logic rd_pslverr(input int d);
        return (d == 1) ? bus1.pslverr : bus0.pslverr;
    endfunction

    function automatic bit legal_addr(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a < 32'(4 * DEPTH));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge pclk) begin
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("pready_w%0d", (d == 1) ? 2 : 0), 32'(rd_pready(d)), 32'(exp_pready[d]));
            if (exp_pready[d]) begin
                chk($sformatf("prdata_w%0d", (d == 1) ? 2 : 0), rd_prdata(d), exp_prdata[d]);
                chk($sformatf("pslverr_w%0d", (d == 1) ? 2 : 0), 32'(rd_pslverr(d)), 32'(exp_pslverr[d]));
            end
        end
    end

    task automatic clear_model();
        for (int d = 0; d < 2; d++) begin
            exp_pready[d] = 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_m[d][i] = 32'h0;
        end
    endtask

    task automatic idle(input int n);
        psel_v    = 2'b00;
        penable_v = 1'b0;
        repeat (n) begin
            @(posedge pclk);
            #1;
        end
    endtask

    // One transfer on instance d. setup=0 continues a back-to-back chain;
    // keep=1 leaves psel/penable high through the pready cycle so the next
    // transfer follows without a setup phase. With keep=0 the master
    // releases the bus during the pready cycle, because the completer
    // decides on back-to-back at the edge closing that cycle.
    task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input bit setup, input bit keep);
        int          w;
        bit          err;
        logic [31:0] rd_exp;
        w      = (d == 1) ? 2 : 0;
        err    = !legal_addr(addr);
        rd_exp = (wr || err) ? 32'h0 : mem_m[d][addr[5:2]];
        first_k[d] = 0;
        psel_v[d]  = 1'b1;
        pwrite_v   = wr;
        paddr_v    = addr;
        pwdata_v   = data;
        if (setup) begin
            penable_v     = 1'b0;
            exp_pready[d] = 1'b0;
            @(posedge pclk);
            #1;
        end
        penable_v = 1'b1;
        for (int k = 1; k <= w + 1; k++) begin
            exp_pready[d]  = (k == w + 1);
            exp_prdata[d]  = rd_exp;
            exp_pslverr[d] = err;
            if (k == w + 1 && !keep) begin
                psel_v[d] = 1'b0;
                penable_v = 1'b0;
            end
            @(negedge pclk);
            if (rd_pready(d) && first_k[d] == 0) begin
                first_k[d]   = k;
                ready_cyc[d] = cyc;
            end
            if (k == w + 1) begin
                last_rd[d]  = rd_prdata(d);
                last_err[d] = rd_pslverr(d);
            end
            @(posedge pclk);
            #1;
        end
        exp_pready[d] = 1'b0;
        if (wr && !err) mem_m[d][addr[5:2]] = data;
        $display("xfer w=%0d %s addr=%h wdata=%h exp_rdata=%h exp_err=%0d b2b_next=%0d",
                 w, wr ? "WR" : "RD", addr, data, rd_exp, err, keep);
    endtask

    // Streaming reads on the zero-wait instance: psel/penable stay high and
    // every cycle completes one word. The next address is presented during
    // the current pready cycle, since that is the edge that samples it.
    task automatic stream_w0(input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                             input logic [31:0] l0, input logic [31:0] l1, input logic [31:0] l2);
        logic [31:0] a   [3];
        logic [31:0] lit [3];
        a[0] = a0; a[1] = a1; a[2] = a2;
        lit[0] = l0; lit[1] = l1; lit[2] = l2;
        psel_v[0] = 1'b1;
        pwrite_v  = 1'b0;
        penable_v = 1'b0;
        paddr_v   = a[0];
        @(posedge pclk);
        #1;
        penable_v = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_pready[0]  = 1'b1;
            exp_prdata[0]  = mem_m[0][a[i][5:2]];
            exp_pslverr[0] = 1'b0;
            if (i < 2) begin
                paddr_v = a[i+1];
            end else begin
                psel_v[0] = 1'b0;
                penable_v = 1'b0;
            end
            @(negedge pclk);
            chk($sformatf("stream_word%0d", i), bus0.prdata, lit[i]);
            $display("stream w=0 RD addr=%h exp_rdata=%h", a[i], lit[i]);
            @(posedge pclk);
            #1;
        end
        exp_pready[0] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int          t1;
        int          d;
        int          len;
        int          r;
        logic [31:0] addr;
        logic [31:0] data;
        bit          wr;

        presetn   = 1'b0;
        psel_v    = 2'b00;
        penable_v = 1'b0;
        pwrite_v  = 1'b0;
        paddr_v   = 32'h0;
        pwdata_v  = 32'h0;
        clear_model();
        repeat (3) @(posedge pclk);
        #1;
        chk("reset_pready", 32'(bus1.pready), 32'h0);
        chk("reset_prdata", bus1.prdata, 32'h0);
        chk("reset_pslverr", 32'(bus1.pslverr), 32'h0);
        presetn = 1'b1;
        idle(2);

        // Basic write / read with two wait states.
        xfer(1, 1'b1, 32'h04, 32'hDEADBEEF, 1'b1, 1'b0);
        chk("wr04_ready_cycle", 32'(first_k[1]), 32'd3);
        xfer(1, 1'b0, 32'h04, 32'h0, 1'b1, 1'b0);
        chk("rd04_ready_cycle", 32'(first_k[1]), 32'd3);
        chk("rd04_data", last_rd[1], 32'hDEADBEEF);
        chk("rd04_err", 32'(last_err[1]), 32'h0);

        // Sweep of the whole bank.
        for (int i = 0; i < DEPTH; i++) begin
            xfer(1, 1'b0, 32'(i * 4), 32'h0, 1'b1, 1'b0);
            chk($sformatf("sweep_idx%0d", i), last_rd[1], (i == 1) ? 32'hDEADBEEF : 32'h0);
        end

        // Error accesses.
        xfer(1, 1'b1, 32'h40, 32'hBAD0BAD0, 1'b1, 1'b0);
        chk("wr40_err", 32'(last_err[1]), 32'h1);
        for (int i = 0; i < DEPTH; i++) xfer(1, 1'b0, 32'(i * 4), 32'h0, 1'b1, 1'b0);
        xfer(1, 1'b0, 32'h06, 32'h0, 1'b1, 1'b0);
        chk("rd06_err", 32'(last_err[1]), 32'h1);
        chk("rd06_data", last_rd[1], 32'h0);

        // Back-to-back writes without a setup phase.
        xfer(1, 1'b1, 32'h00, 32'h11, 1'b1, 1'b1);
        t1 = ready_cyc[1];
        xfer(1, 1'b1, 32'h08, 32'h22, 1'b0, 1'b0);
        chk("b2b_spacing", 32'(ready_cyc[1] - t1), 32'd3);
        xfer(1, 1'b0, 32'h00, 32'h0, 1'b1, 1'b0);
        chk("b2b_rd00", last_rd[1], 32'h11);
        xfer(1, 1'b0, 32'h08, 32'h0, 1'b1, 1'b0);
        chk("b2b_rd08", last_rd[1], 32'h22);

        // Reset arriving in the pready cycle drops the response at once.
        xfer(1, 1'b1, 32'h14, 32'h5A5A5A5A, 1'b1, 1'b0);
        psel_v[1] = 1'b1;
        pwrite_v  = 1'b0;
        paddr_v   = 32'h14;
        penable_v = 1'b0;
        @(posedge pclk);
        #1;
        penable_v = 1'b1;
        repeat (2) begin
            @(posedge pclk);
            #1;
        end
        chk("done_pready_pre_rst", 32'(bus1.pready), 32'h1);
        chk("done_prdata_pre_rst", bus1.prdata, 32'h5A5A5A5A);
        #2;
        presetn = 1'b0;
        clear_model();
        psel_v    = 2'b00;
        penable_v = 1'b0;
        #1;
        chk("async_rst_pready", 32'(bus1.pready), 32'h0);
        chk("async_rst_prdata", bus1.prdata, 32'h0);
        @(posedge pclk);
        #1;
        presetn = 1'b1;
        xfer(1, 1'b0, 32'h14, 32'h0, 1'b1, 1'b0);
        chk("rd14_after_rst", last_rd[1], 32'h0);

        // Reset during the wait of a write: nothing is committed.
        psel_v[1] = 1'b1;
        pwrite_v  = 1'b1;
        paddr_v   = 32'h0C;
        pwdata_v  = 32'h55;
        penable_v = 1'b0;
        @(posedge pclk);
        #1;
        penable_v = 1'b1;
        @(posedge pclk);
        #2;
        presetn = 1'b0;
        clear_model();
        psel_v    = 2'b00;
        penable_v = 1'b0;
        #1;
        chk("wait_rst_pready", 32'(bus1.pready), 32'h0);
        @(posedge pclk);
        #1;
        chk("wait_rst_held_pready", 32'(bus1.pready), 32'h0);
        presetn = 1'b1;
        idle(1);
        xfer(1, 1'b0, 32'h0C, 32'h0, 1'b1, 1'b0);
        chk("rd0c_after_rst", last_rd[1], 32'h0);

        // Abort: psel drops during the wait.
        psel_v[1] = 1'b1;
        pwrite_v  = 1'b1;
        paddr_v   = 32'h10;
        pwdata_v  = 32'h77;
        penable_v = 1'b0;
        @(posedge pclk);
        #1;
        penable_v = 1'b1;
        @(posedge pclk);
        #1;
        idle(3);
        xfer(1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0);
        chk("rd10_after_abort", last_rd[1], 32'h0);

        // Zero-wait instance.
        xfer(0, 1'b1, 32'h00, 32'hA0000000, 1'b1, 1'b0);
        chk("w0_ready_cycle", 32'(first_k[0]), 32'd1);
        xfer(0, 1'b1, 32'h04, 32'hA0000004, 1'b1, 1'b0);
        xfer(0, 1'b1, 32'h08, 32'hA0000008, 1'b1, 1'b0);
        xfer(0, 1'b0, 32'h04, 32'h0, 1'b1, 1'b0);
        chk("w0_rd04", last_rd[0], 32'hA0000004);
        stream_w0(32'h00, 32'h04, 32'h08, 32'hA0000000, 32'hA0000004, 32'hA0000008);
        idle(2);

        // Randomized traffic on both instances.
        for (int n = 0; n < 150; n++) begin
            d   = int'($urandom_range(0, 1));
            len = (d == 1) ? int'($urandom_range(1, 3)) : 1;
            for (int j = 0; j < len; j++) begin
                r = int'($urandom_range(0, 9));
                if (r < 7)       addr = 32'($urandom_range(0, DEPTH - 1) * 4);
                else if (r == 7) addr = 32'h40 + 32'($urandom_range(0, 15) * 4);
                else             addr = 32'($urandom_range(0, 127));
                wr   = 1'($urandom_range(0, 1));
                data = $urandom;
                xfer(d, wr, addr, data, (j == 0), (j < len - 1));
            end
            idle(int'($urandom_range(0, 2)));
        end

        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
